// File: rtl/banco_reg_pkg.sv
// banco_reg_pkg: shared widths and word/address types for the register bank.
// Optional write-data forwarding is selected with macro BANCO_REG_BYPASS_EN.
package banco_reg_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef logic [DATA_W_DEF-1:0] word_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/banco_reg_if.sv
// banco_reg_if: read/write/scoreboard bus of the register bank.
// master drives addresses and write/set controls; slave returns data and busy.
interface banco_reg_if
  import banco_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic [ADDR_W-1:0] A1;
  logic [ADDR_W-1:0] A2;
  logic [ADDR_W-1:0] A3;
  logic [DATA_W-1:0] WD3;
  logic              WE3;
  logic              SE;
  logic [ADDR_W-1:0] SA;
  logic [DATA_W-1:0] RD1;
  logic [DATA_W-1:0] RD2;
  logic              BSY1;
  logic              BSY2;

  modport master (
    output A1, A2, A3, WD3, WE3, SE, SA,
    input  RD1, RD2, BSY1, BSY2
  );

  modport slave (
    input  A1, A2, A3, WD3, WE3, SE, SA,
    output RD1, RD2, BSY1, BSY2
  );

endinterface

// File: rtl/reg_param.sv
// reg_param: W-bit register with load enable and async active-high reset.
// One instance per architectural register of the bank.
module reg_param #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/banco_reg_param.sv
// banco_reg_param: 2R/1W register bank, r0 hardwired to zero, with busy scoreboard.
// Define BANCO_REG_BYPASS_EN to forward same-cycle write data/busy to reads.
module banco_reg_param
  import banco_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic        clk,
  input logic        rst,
  banco_reg_if.slave bus
);

  localparam int NREG = 2 ** ADDR_W;

  logic [NREG-1:0][DATA_W-1:0] regs;
  logic [NREG-1:0]             busy_q;
  logic [NREG-1:0]             busy_d;
  logic                        wr_en;
  logic                        set_en;

  assign wr_en  = bus.WE3 && (bus.A3 != '0);
  assign set_en = bus.SE && (bus.SA != '0);

  assign regs[0] = '0;

  for (genvar i = 1; i < NREG; i++) begin : g_reg
    reg_param #(.W(DATA_W)) u_reg (
      .clk  (clk),
      .rst  (rst),
      .en_i (wr_en && (bus.A3 == ADDR_W'(i))),
      .d_i  (bus.WD3),
      .q_o  (regs[i])
    );
  end

  // Set is applied after clear so a same-address SE wins over the write.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[bus.A3] = 1'b0;
    end
    if (set_en) begin
      busy_d[bus.SA] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

`ifdef BANCO_REG_BYPASS_EN
  logic hit1;
  logic hit2;

  assign hit1 = wr_en && (bus.A1 == bus.A3);
  assign hit2 = wr_en && (bus.A2 == bus.A3);

  assign bus.RD1  = hit1 ? bus.WD3 : regs[bus.A1];
  assign bus.RD2  = hit2 ? bus.WD3 : regs[bus.A2];
  assign bus.BSY1 = hit1 ? busy_d[bus.A1] : busy_q[bus.A1];
  assign bus.BSY2 = hit2 ? busy_d[bus.A2] : busy_q[bus.A2];
`else
  assign bus.RD1  = regs[bus.A1];
  assign bus.RD2  = regs[bus.A2];
  assign bus.BSY1 = busy_q[bus.A1];
  assign bus.BSY2 = busy_q[bus.A2];
`endif

endmodule

// File: tb/tb_banco_reg_param.sv
// tb_banco_reg_param: directed scoreboard bench for banco_reg_param.
// Expectations are queued when stimulus is driven and popped at each check.
module tb_banco_reg_param;
  import banco_reg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string tag;
    int    port;
    word_t rd;
    logic  bsy;
  } exp_t;

  exp_t sb[$];

  banco_reg_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  banco_reg_param #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic expect_port(string tag, int port, word_t rd, logic bsy);
    exp_t e;
    e.tag  = tag;
    e.port = port;
    e.rd   = rd;
    e.bsy  = bsy;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t  e;
    word_t o_rd;
    logic  o_bsy;
    while (sb.size() > 0) begin
      e     = sb.pop_front();
      o_rd  = (e.port == 1) ? bus.RD1 : bus.RD2;
      o_bsy = (e.port == 1) ? bus.BSY1 : bus.BSY2;
      checks++;
      assert (o_rd === e.rd) else begin
        errors++;
        $error("FAIL %s.rd observed=%h expected=%h", e.tag, o_rd, e.rd);
      end
      checks++;
      assert (o_bsy === e.bsy) else begin
        errors++;
        $error("FAIL %s.bsy observed=%b expected=%b", e.tag, o_bsy, e.bsy);
      end
    end
  endtask

  task automatic idle();
    bus.WE3 = 1'b0;
    bus.SE  = 1'b0;
    bus.A3  = '0;
    bus.SA  = '0;
    bus.WD3 = '0;
  endtask

  // Drive controls on the falling edge, let the rising edge commit them.
  task automatic cycle(logic we, addr_t a3, word_t wd, logic se, addr_t sa);
    @(negedge clk);
    bus.WE3 = we;
    bus.A3  = a3;
    bus.WD3 = wd;
    bus.SE  = se;
    bus.SA  = sa;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rd(addr_t a1, addr_t a2);
    bus.A1 = a1;
    bus.A2 = a2;
    #1;
  endtask

  initial begin
    idle();
    bus.A1 = '0;
    bus.A2 = '0;
    repeat (2) @(posedge clk);
    #1;
    rd(5, 9);
    expect_port("reset_rd1", 1, 32'h0, 1'b0);
    expect_port("reset_rd2", 2, 32'h0, 1'b0);
    check_all();
    @(negedge clk);
    rst = 1'b0;

    cycle(1'b1, 5, 32'hDEADBEEF, 1'b0, 0);
    rd(5, 5);
    expect_port("r5_rd1", 1, 32'hDEADBEEF, 1'b0);
    expect_port("r5_rd2", 2, 32'hDEADBEEF, 1'b0);
    check_all();

    cycle(1'b1, 0, 32'hFFFFFFFF, 1'b1, 0);
    rd(0, 0);
    expect_port("r0_rd1", 1, 32'h0, 1'b0);
    expect_port("r0_rd2", 2, 32'h0, 1'b0);
    check_all();

    cycle(1'b0, 0, 32'h0, 1'b1, 7);
    rd(7, 5);
    expect_port("set7", 1, 32'h0, 1'b1);
    expect_port("r5_keep", 2, 32'hDEADBEEF, 1'b0);
    check_all();

    cycle(1'b0, 0, 32'h0, 1'b1, 7);
    rd(7, 7);
    expect_port("set7_again", 1, 32'h0, 1'b1);
    check_all();

    cycle(1'b1, 7, 32'h12, 1'b0, 0);
    rd(7, 7);
    expect_port("wr7_clr", 1, 32'h12, 1'b0);
    expect_port("wr7_clr2", 2, 32'h12, 1'b0);
    check_all();

    cycle(1'b1, 9, 32'h55, 1'b1, 9);
    rd(9, 9);
    expect_port("same9_1", 1, 32'h55, 1'b1);
    expect_port("same9_2", 2, 32'h55, 1'b1);
    check_all();

    cycle(1'b1, 11, 32'h66, 1'b1, 10);
    rd(10, 11);
    expect_port("diff_set10", 1, 32'h0, 1'b1);
    expect_port("diff_wr11", 2, 32'h66, 1'b0);
    check_all();

    cycle(1'b1, 31, 32'hCAFE0031, 1'b1, 12);
    rd(31, 12);
    expect_port("top31", 1, 32'hCAFE0031, 1'b0);
    expect_port("set12", 2, 32'h0, 1'b1);
    check_all();

    // Same-cycle write with reads on the target: forwarded or old state.
    @(negedge clk);
    bus.WE3 = 1'b1;
    bus.A3  = 3;
    bus.WD3 = 32'hA5A5;
    rd(3, 3);
`ifdef BANCO_REG_BYPASS_EN
    expect_port("byp3", 1, 32'hA5A5, 1'b0);
`else
    expect_port("byp3", 1, 32'h0, 1'b0);
`endif
    check_all();
    @(posedge clk);
    #1;
    idle();
    rd(3, 3);
    expect_port("r3_after", 1, 32'hA5A5, 1'b0);
    check_all();

    @(negedge clk);
    bus.WE3 = 1'b1;
    bus.A3  = 12;
    bus.WD3 = 32'h1212;
    rd(0, 12);
`ifdef BANCO_REG_BYPASS_EN
    expect_port("byp12", 2, 32'h1212, 1'b0);
`else
    expect_port("byp12", 2, 32'h0, 1'b1);
`endif
    check_all();
    @(posedge clk);
    #1;
    idle();
    rd(12, 12);
    expect_port("r12_after", 1, 32'h1212, 1'b0);
    check_all();

    cycle(1'b1, 4, 32'h77, 1'b1, 4);
    rd(4, 9);
    expect_port("r4_set", 1, 32'h77, 1'b1);
    expect_port("r9_set", 2, 32'h55, 1'b1);
    check_all();

    // Reset in mid-cycle with a write pending: clears at once, write lost.
    @(negedge clk);
    bus.WE3 = 1'b1;
    bus.A3  = 6;
    bus.WD3 = 32'h99;
    bus.SE  = 1'b1;
    bus.SA  = 6;
    #2;
    rst = 1'b1;
    rd(4, 9);
    expect_port("rst_async4", 1, 32'h0, 1'b0);
    expect_port("rst_async9", 2, 32'h0, 1'b0);
    check_all();
    @(posedge clk);
    #1;
    rd(6, 5);
    expect_port("rst_drop6", 1, 32'h0, 1'b0);
    expect_port("rst_r5", 2, 32'h0, 1'b0);
    check_all();
    @(negedge clk);
    rst = 1'b0;
    idle();

    cycle(1'b1, 6, 32'h33, 1'b1, 8);
    rd(6, 8);
    expect_port("resume6", 1, 32'h33, 1'b0);
    expect_port("resume8", 2, 32'h0, 1'b1);
    check_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
